// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types and the round-robin pick function for the Avalon-MM arbiter.
package avalon_arb_pkg;

  localparam int MAX_HOSTS = 8;

  typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req scanning last+1, last+2, ... modulo n.
  // Scanning the offsets downwards lets the nearest candidate overwrite the rest.
  // Passing last = n-1 degenerates into lowest-index-wins.
  function automatic pick_t rr_pick(input logic [MAX_HOSTS-1:0] req,
                                    input logic [2:0] last, input int n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = n; k >= 1; k--) begin
      j = (int'(last) + k) % n;
      if (req[j]) begin
        r.valid = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_rsp_id_fifo.sv
// Read-ID FIFO: remembers which host owns each outstanding read, in issue order.
module rsp_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// N-host to 1-agent Avalon-MM arbiter with pipelined read-return routing.
module avalon_mm_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int N_HOSTS         = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_HOSTS-1:0][ADDR_W-1:0]      h_address,
  input  logic [N_HOSTS-1:0]                  h_read,
  input  logic [N_HOSTS-1:0]                  h_write,
  input  logic [N_HOSTS-1:0][DATA_W-1:0]      h_writedata,
  input  logic [N_HOSTS-1:0][DATA_W/8-1:0]    h_byteenable,
  output logic [N_HOSTS-1:0]                  h_waitrequest,
  output logic [DATA_W-1:0]                   h_readdata,
  output logic [N_HOSTS-1:0]                  h_readdatavalid,
  output logic [ADDR_W-1:0]                   a_address,
  output logic                                a_read,
  output logic                                a_write,
  output logic [DATA_W-1:0]                   a_writedata,
  output logic [DATA_W/8-1:0]                 a_byteenable,
  input  logic                                a_waitrequest,
  input  logic [DATA_W-1:0]                   a_readdata,
  input  logic                                a_readdatavalid,
  output logic                                err_unexpected_rsp
);

  localparam int GW = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam arb_mode_e MODE = arb_mode_e'(ARB_MODE[0]);
  localparam logic [CW-1:0] MAX_CNT = MAX_OUTSTANDING[CW-1:0];

  arb_state_e            state_q;
  logic [GW-1:0]         grant_q, last_q;
  logic                  err_q;

  logic [N_HOSTS-1:0]    elig;
  logic [MAX_HOSTS-1:0]  req8;
  pick_t                 pick;
  logic                  granted, g_req, accept, push, pop, rd_blocked;
  logic [GW-1:0]         fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  unused_pick;

  // A host asserting both strobes is served as a write; reads wait while the
  // registered FIFO count says every ID slot is taken.
  assign rd_blocked = (fifo_count == MAX_CNT);
  assign elig       = h_write | (h_read & ~h_write & {N_HOSTS{~rd_blocked}});

  // Winner selection; fixed priority is round-robin anchored at the top index.
  always_comb begin
    req8              = '0;
    req8[N_HOSTS-1:0] = elig;
    if (MODE == ARB_FIXED) pick = rr_pick(req8, 3'(N_HOSTS - 1), N_HOSTS);
    else                   pick = rr_pick(req8, 3'(last_q), N_HOSTS);
  end
  assign unused_pick = &{1'b0, pick.idx};

  assign granted = (state_q == GRANTED);
  assign g_req   = h_read[grant_q] | h_write[grant_q];

  // Agent side is a straight mux of the granted host; zero when nothing is live.
  always_comb begin
    a_read       = 1'b0;
    a_write      = 1'b0;
    a_address    = '0;
    a_writedata  = '0;
    a_byteenable = '0;
    if (granted && g_req) begin
      a_write      = h_write[grant_q];
      a_read       = h_read[grant_q] & ~h_write[grant_q];
      a_address    = h_address[grant_q];
      a_writedata  = h_writedata[grant_q];
      a_byteenable = h_byteenable[grant_q];
    end
  end

  assign accept = (a_read | a_write) & ~a_waitrequest;
  assign push   = accept & a_read & ~fifo_full;
  assign pop    = a_readdatavalid & ~fifo_empty;

  // Only the granted host sees the agent's stall; everyone else is held off.
  always_comb begin
    h_waitrequest = '1;
    if (granted) h_waitrequest[grant_q] = a_waitrequest;
  end

  // Read data is broadcast; the strobe goes to the host at the FIFO head.
  always_comb begin
    h_readdatavalid = '0;
    if (pop) h_readdatavalid[fifo_dout] = 1'b1;
  end
  assign h_readdata         = a_readdata;
  assign err_unexpected_rsp = err_q;

  // Arbitration FSM plus the sticky orphan-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_HOSTS - 1);
      err_q   <= 1'b0;
    end else begin
      if (a_readdatavalid && fifo_empty) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pick.valid) begin
            grant_q <= GW'(pick.idx);
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (accept) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end else if (!g_req) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rsp_id_fifo #(
    .WIDTH (GW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (grant_q),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter share host stimulus.
module tb_avalon_mm_arbiter;
  localparam int N = 2, AW = 32, DW = 32, MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0]   h_address;
  logic [N-1:0]           h_read, h_write;
  logic [N-1:0][DW-1:0]   h_writedata;
  logic [N-1:0][DW/8-1:0] h_byteenable;
  logic                   a_wait, auto_rsp, man_rv;
  logic [DW-1:0]          man_rd;

  logic [N-1:0]      hw  [2];
  logic [N-1:0]      hrv [2];
  logic [DW-1:0]     hrd [2];
  logic [AW-1:0]     aa  [2];
  logic              ar  [2];
  logic              aw  [2];
  logic [DW-1:0]     awd [2];
  logic [DW/8-1:0]   abe [2];
  logic              err [2];
  logic              arv [2];
  logic [DW-1:0]     ard [2];

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [1:0]         rv_pipe;
    logic [1:0][DW-1:0] rd_pipe;

    // Agent model: answers each accepted read two cycles later with addr ^ A5A50000.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        rv_pipe <= '0;
        rd_pipe <= '0;
      end else begin
        rv_pipe <= {rv_pipe[0], ar[k] & ~a_wait};
        rd_pipe <= {rd_pipe[0], aa[k] ^ 32'hA5A50000};
      end
    end
    assign arv[k] = auto_rsp ? rv_pipe[1] : man_rv;
    assign ard[k] = auto_rsp ? rd_pipe[1] : man_rd;

    avalon_mm_arbiter #(
      .N_HOSTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .ARB_MODE(k)
    ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .h_address          (h_address),
      .h_read             (h_read),
      .h_write            (h_write),
      .h_writedata        (h_writedata),
      .h_byteenable       (h_byteenable),
      .h_waitrequest      (hw[k]),
      .h_readdata         (hrd[k]),
      .h_readdatavalid    (hrv[k]),
      .a_address          (aa[k]),
      .a_read             (ar[k]),
      .a_write            (aw[k]),
      .a_writedata        (awd[k]),
      .a_byteenable       (abe[k]),
      .a_waitrequest      (a_wait),
      .a_readdata         (ard[k]),
      .a_readdatavalid    (arv[k]),
      .err_unexpected_rsp (err[k])
    );
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    samp();
    checks++; if (hw[0] !== 2'b11) begin errors++; $display("FAIL rst_hw got %b want 11", hw[0]); end
    checks++; if (hrv[0] !== 2'b00) begin errors++; $display("FAIL rst_hrv got %b want 00", hrv[0]); end
    checks++; if ({ar[0], aw[0]} !== 2'b00) begin errors++; $display("FAIL rst_rdwr got %b want 00", {ar[0], aw[0]}); end
    checks++; if (aa[0] !== '0 || awd[0] !== '0 || abe[0] !== '0) begin
      errors++; $display("FAIL rst_abus got %h/%h/%h want 0", aa[0], awd[0], abe[0]); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err[0]); end
    cyc(); rst = 1'b1;
    cyc();
  endtask

  task automatic test_rr();
    logic [AW-1:0] exp_a [4];
    logic [N-1:0]  exp_v [4];
    int na, nr;
    exp_a = '{32'h100, 32'h200, 32'h100, 32'h200};
    exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
    na = 0; nr = 0;
    auto_rsp = 1'b1; a_wait = 1'b0;
    h_address[0] = 32'h100; h_address[1] = 32'h200;
    for (int c = 0; c < 16; c++) begin
      cyc(); h_read = 2'b11; samp();
      if (ar[0]) begin
        if (na < 4) begin
          checks++; if (aa[0] !== exp_a[na]) begin errors++; $display("FAIL rr_addr%0d got %h want %h", na, aa[0], exp_a[na]); end
        end
        na++;
      end
      if (hrv[0] != '0) begin
        if (nr < 4) begin
          checks++; if (hrv[0] !== exp_v[nr]) begin errors++; $display("FAIL rr_rdv%0d got %b want %b", nr, hrv[0], exp_v[nr]); end
          checks++; if (hrd[0] !== (exp_a[nr] ^ 32'hA5A50000)) begin
            errors++; $display("FAIL rr_rdata%0d got %h want %h", nr, hrd[0], exp_a[nr] ^ 32'hA5A50000); end
        end
        nr++;
      end
    end
    checks++; if (na != 8) begin errors++; $display("FAIL rr_ncmd got %0d want 8", na); end
    checks++; if (nr != 7) begin errors++; $display("FAIL rr_nrsp got %0d want 7", nr); end
    cyc(); h_read = 2'b00;
    repeat (4) cyc();
  endtask

  task automatic test_fixed();
    int n;
    int bad_hw;
    n = 0; bad_hw = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(); h_read = 2'b11; samp();
      if (ar[1]) begin
        checks++; if (aa[1] !== 32'h100) begin errors++; $display("FAIL fix_addr got %h want 00000100", aa[1]); end
        n++;
      end
      checks++; if (hw[1][1] !== 1'b1) begin errors++; $display("FAIL fix_starve_hw cyc%0d got %b want 1", c, hw[1][1]); end
      checks++; if (hrv[1][1] !== 1'b0) begin errors++; $display("FAIL fix_rdv1 cyc%0d got %b want 0", c, hrv[1][1]); end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL fix_ncmd got %0d want 8", n); end
    cyc(); h_read = 2'b00;
    repeat (4) cyc();
  endtask

  task automatic test_max_outstanding();
    int acc;
    acc = 0;
    auto_rsp = 1'b0; man_rv = 1'b0; man_rd = '0; a_wait = 1'b0;
    h_address[0] = 32'h300;
    for (int c = 0; c < 30 && acc < 4; c++) begin
      cyc(); h_read = 2'b01; samp();
      if (!hw[0][0]) acc++;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL mo_accepted got %0d want 4", acc); end
    for (int c = 0; c < 6; c++) begin
      cyc(); samp();
      checks++; if (hw[0][0] !== 1'b1 || ar[0] !== 1'b0) begin
        errors++; $display("FAIL mo_blocked cyc%0d got hw=%b rd=%b want hw=1 rd=0", c, hw[0][0], ar[0]); end
    end
    cyc(); man_rv = 1'b1; man_rd = 32'h12345678; samp();
    checks++; if (hrv[0] !== 2'b01) begin errors++; $display("FAIL mo_pop_rdv got %b want 01", hrv[0]); end
    checks++; if (hrd[0] !== 32'h12345678) begin errors++; $display("FAIL mo_pop_data got %h want 12345678", hrd[0]); end
    checks++; if (ar[0] !== 1'b0) begin errors++; $display("FAIL mo_pop_cycle_rd got %b want 0", ar[0]); end
    cyc(); man_rv = 1'b0; samp();
    checks++; if (ar[0] !== 1'b0) begin errors++; $display("FAIL mo_arb_cycle_rd got %b want 0", ar[0]); end
    cyc(); samp();
    checks++; if (ar[0] !== 1'b1 || hw[0][0] !== 1'b0) begin
      errors++; $display("FAIL mo_fifth got rd=%b hw=%b want rd=1 hw=0", ar[0], hw[0][0]); end
    cyc(); h_read = 2'b00; samp();
    for (int i = 0; i < 4; i++) begin
      cyc(); man_rv = 1'b1; samp();
      checks++; if (hrv[0] !== 2'b01) begin errors++; $display("FAIL mo_drain%0d got %b want 01", i, hrv[0]); end
      cyc(); man_rv = 1'b0;
    end
  endtask

  task automatic test_write_wait();
    a_wait = 1'b1;
    cyc();
    h_write = 2'b10; h_address[1] = 32'h10; h_writedata[1] = 32'hDEADBEEF; h_byteenable[1] = 4'hF;
    samp();
    checks++; if (aw[0] !== 1'b0 || hw[0] !== 2'b11) begin
      errors++; $display("FAIL wr_idle got wr=%b hw=%b want wr=0 hw=11", aw[0], hw[0]); end
    for (int i = 0; i < 3; i++) begin
      cyc(); samp();
      checks++; if (aw[0] !== 1'b1 || ar[0] !== 1'b0 || aa[0] !== 32'h10 || awd[0] !== 32'hDEADBEEF || abe[0] !== 4'hF) begin
        errors++; $display("FAIL wr_hold%0d got wr=%b rd=%b a=%h d=%h be=%h want 1 0 10 deadbeef f",
                           i, aw[0], ar[0], aa[0], awd[0], abe[0]); end
      checks++; if (hw[0] !== 2'b11) begin errors++; $display("FAIL wr_mirror%0d got %b want 11", i, hw[0]); end
    end
    cyc(); a_wait = 1'b0; samp();
    checks++; if (aw[0] !== 1'b1 || hw[0] !== 2'b01) begin
      errors++; $display("FAIL wr_accept got wr=%b hw=%b want wr=1 hw=01", aw[0], hw[0]); end
    cyc(); h_write = 2'b00; samp();
    checks++; if (aw[0] !== 1'b0) begin errors++; $display("FAIL wr_done got %b want 0", aw[0]); end
  endtask

  task automatic test_unexpected_rsp();
    cyc(); man_rv = 1'b1; man_rd = 32'hCAFE; samp();
    checks++; if (hrv[0] !== 2'b00) begin errors++; $display("FAIL ur_rdv got %b want 00", hrv[0]); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL ur_err_same got %b want 0", err[0]); end
    cyc(); man_rv = 1'b0; samp();
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL ur_err_set got %b want 1", err[0]); end
    for (int i = 0; i < 3; i++) begin
      cyc(); samp();
      checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL ur_err_sticky%0d got %b want 1", i, err[0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic done;
    h_address[0] = 32'h600; h_address[1] = 32'h500;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      cyc(); h_read = 2'b10; samp();
      if (!hw[0][1]) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL rm_h1_read got timeout want accept"); end
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      cyc(); h_read = 2'b01; samp();
      if (!hw[0][0]) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL rm_h0_read got timeout want accept"); end
    cyc(); h_read = 2'b00; samp();
    cyc(); rst = 1'b0; #1;
    checks++; if (hw[0] !== 2'b11 || hrv[0] !== 2'b00) begin
      errors++; $display("FAIL rm_host_side got hw=%b rdv=%b want 11 00", hw[0], hrv[0]); end
    checks++; if (ar[0] !== 1'b0 || aw[0] !== 1'b0 || aa[0] !== '0) begin
      errors++; $display("FAIL rm_agent_side got rd=%b wr=%b a=%h want 0 0 0", ar[0], aw[0], aa[0]); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rm_err_clr got %b want 0", err[0]); end
    cyc(); rst = 1'b1; samp();
    cyc(); man_rv = 1'b1; samp();
    checks++; if (hrv[0] !== 2'b00) begin errors++; $display("FAIL rm_stale_rdv got %b want 00", hrv[0]); end
    cyc(); man_rv = 1'b0; samp();
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL rm_stale_err got %b want 1", err[0]); end
    cyc(); h_read = 2'b11; samp();
    checks++; if (ar[0] !== 1'b0) begin errors++; $display("FAIL rm_arb_idle got %b want 0", ar[0]); end
    cyc(); samp();
    checks++; if (ar[0] !== 1'b1 || aa[0] !== 32'h600 || hw[0] !== 2'b10) begin
      errors++; $display("FAIL rm_first_win got rd=%b a=%h hw=%b want 1 600 10", ar[0], aa[0], hw[0]); end
    cyc(); h_read = 2'b00; samp();
  endtask

  initial begin
    h_address = '0; h_read = '0; h_write = '0; h_writedata = '0; h_byteenable = '0;
    a_wait = 1'b0; auto_rsp = 1'b0; man_rv = 1'b0; man_rd = '0;
    test_reset();
    test_rr();
    test_fixed();
    test_max_outstanding();
    test_write_wait();
    test_unexpected_rsp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
